cpu_intctrl: RTL and testbench

Parametrised vectored interrupt controller with built-in countdown timers. It generalises the single timer and single pending flag of the CPU exception unit to NUM_TIMERS timers plus NUM_EXT external sources. Each source has pending, enable, edge/level mode and fixed priority, and higher-priority sources may preempt (nested interrupts). It sits beside the exception unit: it presents one request with a cause and vector, the exception unit acknowledges it at P4, and RTI signals end-of-interrupt. Its registers are accessed through the P3 CSR path.

---
 rtl/cpu_intctrl_pkg.sv | 57 +++++
 rtl/cpu_intctrl_timer.sv | 37 +++
 rtl/cpu_intctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_cpu_intctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_intctrl_pkg.sv
// Shared constants, register-select encoding and bit helpers for the
// vectored interrupt controller.
package cpu_intctrl_pkg;

    // Register offsets relative to the block's first CSR number
    localparam logic [3:0] INTC_IPEND    = 4'd0;
    localparam logic [3:0] INTC_IENABLE  = 4'd1;
    localparam logic [3:0] INTC_IINSERV  = 4'd2;
    localparam logic [3:0] INTC_IVECBASE = 4'd3;
    localparam logic [3:0] INTC_TIMER0   = 4'd4;

    // The block claims 16 CSR numbers: enough for 4 fixed registers plus
    // up to 4 timers, the remainder read as zero
    localparam int INTC_SPAN       = 16;
    localparam int INTC_VEC_STRIDE = 8;

    localparam logic [31:0] INTC_VECBASE_RESET = 32'hffff_0008;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_IPEND,
        SEL_IENABLE,
        SEL_IINSERV,
        SEL_IVECBASE,
        SEL_TCOUNT,
        SEL_TRELOAD
    } csrSel_e;

    // Isolate the lowest set bit of a vector (zero stays zero)
    function automatic logic [31:0] lowestBit(input logic [31:0] v);
        return v & (~v + 32'd1);
    endfunction

    // Index of the lowest set bit; zero when the vector is empty
    function automatic logic [4:0] firstIndex(input logic [31:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

    // Sources whose pending bit is held in a flop: every timer and every
    // edge-triggered external input
    function automatic logic [31:0] storedMask(input int nt, input int ne,
                                               input logic [31:0] em);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < nt) m[i] = 1'b1;
            else if (i < nt + ne) m[i] = em[i - nt];
        end
        return m;
    endfunction

endpackage

// File: rtl/cpu_intctrl_timer.sv
// One countdown timer: count and reload registers with a CSR write port.
// o_zero pulses for the cycle in which the count steps from 1 to 0.
module intc_timer
    import cpu_intctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        i_countWr,
    input  logic        i_reloadWr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_reload,
    output logic        o_zero
);

    logic [31:0] r_count;
    logic [31:0] r_reload;

    // A software write to the count beats the decrement of that cycle
    assign o_zero   = !i_countWr && (r_count == 32'd1);
    assign o_count  = r_count;
    assign o_reload = r_reload;

    // Count down while non-zero; on expiry reload (reload of 0 stops the timer)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count  <= '0;
            r_reload <= '0;
        end else begin
            if (i_reloadWr) r_reload <= i_wdata;
            if (i_countWr) r_count <= i_wdata;
            else if (r_count == 32'd1) r_count <= r_reload;
            else if (r_count != 32'd0) r_count <= r_count - 32'd1;
        end
    end

endmodule

// File: rtl/cpu_intctrl.sv
// Vectored interrupt controller with countdown timers. Timers occupy the
// lowest source indices, external inputs follow; lower index wins and a
// source may preempt only handlers of strictly lower priority.
module cpu_intctrl
    import cpu_intctrl_pkg::*;
#(
    parameter int          NUM_EXT    = 8,
    parameter int          NUM_TIMERS = 2,
    parameter logic [31:0] EDGE_MASK  = 32'h0000_00FF,
    parameter logic [12:0] CSR_BASE   = 13'h0040
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic [NUM_EXT-1:0] ext_irq,
    input  logic               csr_wr,
    input  logic               csr_rd,
    input  logic [12:0]        csr_addr,
    input  logic [31:0]        csr_wdata,
    output logic [31:0]        csr_rdata,
    output logic               csr_hit,
    input  logic               irq_global_en,
    output logic               irq_req,
    output logic [4:0]         irq_cause,
    output logic [31:0]        irq_vector,
    input  logic               irq_ack,
    input  logic               irq_eoi
);

    localparam int          NSRC        = NUM_TIMERS + NUM_EXT;
    localparam logic [31:0] SRC_MASK    = 32'((64'd1 << NSRC) - 64'd1);
    localparam logic [31:0] STORED_MASK = storedMask(NUM_TIMERS, NUM_EXT, EDGE_MASK) & SRC_MASK;
    localparam logic [31:0] LEVEL_MASK  = SRC_MASK & ~STORED_MASK;

    logic [NUM_EXT-1:0] r_sync1;
    logic [NUM_EXT-1:0] r_sync2;
    logic [NUM_EXT-1:0] r_syncPrev;
    logic [31:0]        r_pendStore;
    logic [31:0]        r_enable;
    logic [31:0]        r_inserv;
    logic [31:0]        r_vecBase;
    logic               r_irqReq;
    logic [4:0]         r_irqCause;
    logic [31:0]        r_irqVector;
    logic [31:0]        r_csrRdata;
    logic               r_csrHit;

    logic [12:0]        w_offset;
    logic               w_inRange;
    logic [3:0]         w_lowOff;
    logic [2:0]         w_tIdx;
    csrSel_e            w_sel;
    logic               w_wrEn;
    logic [31:0]        w_rdMux;

    logic [31:0]           w_tCount  [NUM_TIMERS];
    logic [31:0]           w_tReload [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] w_tZero;

    logic [NUM_EXT-1:0] w_extRise;
    logic [31:0]        w_hwSet;
    logic [31:0]        w_w1c;
    logic [31:0]        w_pending;
    logic [31:0]        w_active;
    logic [4:0]         w_winIdx;
    logic [31:0]        w_insLow;
    logic               w_priorityOk;
    logic               w_reqCond;
    logic               w_reqNext;
    logic               w_ackValid;
    logic               w_eoiValid;
    logic [31:0]        w_ackBit;
    logic [31:0]        w_insAfterEoi;

    assign w_offset  = csr_addr - CSR_BASE;
    assign w_inRange = (w_offset < 13'(INTC_SPAN));
    assign w_wrEn    = csr_wr && !stall;

    // Decode the CSR number into a register select and timer index
    always_comb begin
        w_sel    = SEL_NONE;
        w_tIdx   = '0;
        w_lowOff = w_offset[3:0] - INTC_TIMER0;
        if (w_inRange) begin
            case (w_offset[3:0])
                INTC_IPEND:    w_sel = SEL_IPEND;
                INTC_IENABLE:  w_sel = SEL_IENABLE;
                INTC_IINSERV:  w_sel = SEL_IINSERV;
                INTC_IVECBASE: w_sel = SEL_IVECBASE;
                default: begin
                    w_tIdx = w_lowOff[3:1];
                    if (w_lowOff[3:1] < 3'(NUM_TIMERS))
                        w_sel = w_lowOff[0] ? SEL_TRELOAD : SEL_TCOUNT;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NUM_TIMERS; k++) begin : g_timer
        intc_timer u_timer (
            .clock      (clock),
            .reset      (reset),
            .i_countWr  (w_wrEn && (w_sel == SEL_TCOUNT)  && (w_tIdx == 3'(k))),
            .i_reloadWr (w_wrEn && (w_sel == SEL_TRELOAD) && (w_tIdx == 3'(k))),
            .i_wdata    (csr_wdata),
            .o_count    (w_tCount[k]),
            .o_reload   (w_tReload[k]),
            .o_zero     (w_tZero[k])
        );
    end

    // Level sources are never stored: their pending bit is the synchronised line
    assign w_pending = r_pendStore | ((32'(r_sync2) << NUM_TIMERS) & LEVEL_MASK);
    assign w_extRise = r_sync2 & ~r_syncPrev;
    assign w_hwSet   = (32'(w_tZero) | (32'(w_extRise) << NUM_TIMERS)) & STORED_MASK;
    assign w_w1c     = (w_wrEn && (w_sel == SEL_IPEND)) ? (csr_wdata & SRC_MASK) : '0;

    // An ack only counts while a request is actually being presented
    assign w_ackValid    = irq_ack && !stall && r_irqReq;
    assign w_eoiValid    = irq_eoi && !stall;
    assign w_ackBit      = w_ackValid ? (32'd1 << r_irqCause) : '0;
    assign w_insAfterEoi = w_eoiValid ? (r_inserv & (r_inserv - 32'd1)) : r_inserv;

    // The winner must sit strictly below the highest-priority handler in service
    assign w_active     = w_pending & r_enable;
    assign w_winIdx     = firstIndex(w_active);
    assign w_insLow     = lowestBit(r_inserv);
    assign w_priorityOk = (r_inserv == '0) || ((w_active & (w_insLow - 32'd1)) != '0);
    assign w_reqCond    = (w_active != '0) && irq_global_en && w_priorityOk;
    assign w_reqNext    = w_reqCond && !w_ackValid;

    // Two-flop synchroniser plus a delayed copy for rising-edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_syncPrev <= '0;
        end else begin
            r_sync1    <= ext_irq;
            r_sync2    <= r_sync1;
            r_syncPrev <= r_sync2;
        end
    end

    // Stored pending bits: a hardware set beats both W1C and ack clearing
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_pendStore <= '0;
        else        r_pendStore <= ((r_pendStore & ~w_w1c & ~w_ackBit) | w_hwSet) & STORED_MASK;
    end

    // Software-owned configuration registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_enable  <= '0;
            r_vecBase <= INTC_VECBASE_RESET;
        end else if (w_wrEn) begin
            if (w_sel == SEL_IENABLE)  r_enable  <= csr_wdata & SRC_MASK;
            if (w_sel == SEL_IVECBASE) r_vecBase <= {csr_wdata[31:3], 3'b000};
        end
    end

    // In-service stack as a bitmap: EOI retires the innermost level, then ack pushes
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_inserv <= '0;
        else        r_inserv <= w_insAfterEoi | w_ackBit;
    end

    // Request, cause and vector move together so the exception unit sees a coherent set
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_irqReq    <= 1'b0;
            r_irqCause  <= '0;
            r_irqVector <= INTC_VECBASE_RESET;
        end else begin
            r_irqReq <= w_reqNext;
            if (w_reqNext) begin
                r_irqCause  <= w_winIdx;
                r_irqVector <= r_vecBase + 32'(w_winIdx) * 32'(INTC_VEC_STRIDE);
            end
        end
    end

    // Read data selection for the addressed register
    always_comb begin
        w_rdMux = '0;
        case (w_sel)
            SEL_IPEND:    w_rdMux = w_pending;
            SEL_IENABLE:  w_rdMux = r_enable;
            SEL_IINSERV:  w_rdMux = r_inserv;
            SEL_IVECBASE: w_rdMux = r_vecBase;
            SEL_TCOUNT: begin
                for (int k = 0; k < NUM_TIMERS; k++)
                    if (w_tIdx == 3'(k)) w_rdMux = w_tCount[k];
            end
            SEL_TRELOAD: begin
                for (int k = 0; k < NUM_TIMERS; k++)
                    if (w_tIdx == 3'(k)) w_rdMux = w_tReload[k];
            end
            default: w_rdMux = '0;
        endcase
    end

    // Register the read result for P4; a stalled pipeline keeps the old value
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_csrRdata <= '0;
            r_csrHit   <= 1'b0;
        end else if (!stall) begin
            r_csrRdata <= csr_rd ? w_rdMux : '0;
            r_csrHit   <= w_inRange && (csr_rd || csr_wr);
        end
    end

    assign csr_rdata  = r_csrRdata;
    assign csr_hit    = r_csrHit;
    assign irq_req    = r_irqReq;
    assign irq_cause  = r_irqCause;
    assign irq_vector = r_irqVector;

endmodule

// File: tb/tb_cpu_intctrl.sv
// Self-checking bench for cpu_intctrl: register table, directed interrupt
// sequences and a randomized run against a behavioural model.
module tb_cpu_intctrl;

    localparam int          NE   = 8;
    localparam int          NT   = 2;
    localparam int          NSRC = NE + NT;
    localparam logic [31:0] EDGE = 32'h0000_000F;
    localparam logic [12:0] BASE = 13'h0040;
    localparam logic [31:0] SRCM = 32'h0000_03FF;

    logic          clock;
    logic          reset;
    logic          stall;
    logic [NE-1:0] ext_irq;
    logic          csr_wr;
    logic          csr_rd;
    logic [12:0]   csr_addr;
    logic [31:0]   csr_wdata;
    logic [31:0]   csr_rdata;
    logic          csr_hit;
    logic          irq_global_en;
    logic          irq_req;
    logic [4:0]    irq_cause;
    logic [31:0]   irq_vector;
    logic          irq_ack;
    logic          irq_eoi;

    int checks   = 0;
    int failures = 0;

    cpu_intctrl #(.NUM_EXT(NE), .NUM_TIMERS(NT), .EDGE_MASK(EDGE), .CSR_BASE(BASE)) dut (
        .clock(clock), .reset(reset), .stall(stall), .ext_irq(ext_irq),
        .csr_wr(csr_wr), .csr_rd(csr_rd), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_hit(csr_hit), .irq_global_en(irq_global_en),
        .irq_req(irq_req), .irq_cause(irq_cause), .irq_vector(irq_vector),
        .irq_ack(irq_ack), .irq_eoi(irq_eoi)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural model state
    bit [31:0]   mStored, mEnable, mInserv, mVecbase, mVector, mRdata;
    bit [4:0]    mCause;
    bit          mReq, mHit;
    int unsigned mCount [NT];
    int unsigned mReload [NT];
    bit [NE-1:0] mD1, mD2, mD3;

    typedef struct {
        bit        isWrite;
        int        off;
        bit [31:0] wdata;
        bit [31:0] expData;
        bit        expHit;
    } vec_t;

    vec_t tbl [19];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mStored = '0; mEnable = '0; mInserv = '0; mVecbase = 32'hffff_0008;
        mReq = 1'b0; mCause = '0; mVector = 32'hffff_0008; mRdata = '0; mHit = 1'b0;
        mD1 = '0; mD2 = '0; mD3 = '0;
        for (int k = 0; k < NT; k++) begin mCount[k] = 0; mReload[k] = 0; end
    endtask

    function automatic bit isStoredSrc(int s);
        if (s < NT) return 1'b1;
        if (s < NSRC) return EDGE[s - NT];
        return 1'b0;
    endfunction

    function automatic bit [31:0] modelPending();
        bit [31:0] p;
        p = mStored;
        for (int j = 0; j < NE; j++) if (!EDGE[j] && mD2[j]) p[NT + j] = 1'b1;
        return p;
    endfunction

    function automatic bit [31:0] modelRead(int off);
        if (off == 0) return modelPending();
        if (off == 1) return mEnable;
        if (off == 2) return mInserv;
        if (off == 3) return mVecbase;
        if (off >= 4 && off < 4 + 2 * NT) begin
            if (off % 2 == 0) return mCount[(off - 4) / 2];
            return mReload[(off - 4) / 2];
        end
        return 32'd0;
    endfunction

    // One clock of the controller's rules, evaluated on pre-edge state
    task automatic modelStep();
        bit [31:0] pend, active, setv, clr, oldVec;
        int win, lowIns, off;
        bit wr, ackOk, eoiOk, reqN;
        pend   = modelPending();
        active = pend & mEnable;
        win = -1;
        for (int i = NSRC - 1; i >= 0; i--) if (active[i]) win = i;
        lowIns = -1;
        for (int i = NSRC - 1; i >= 0; i--) if (mInserv[i]) lowIns = i;
        wr    = csr_wr && !stall;
        ackOk = irq_ack && !stall && mReq;
        eoiOk = irq_eoi && !stall;
        off   = int'(csr_addr) - int'(BASE);
        reqN  = (win >= 0) && irq_global_en && (lowIns < 0 || win < lowIns) && !ackOk;
        oldVec = mVecbase;
        if (!stall) begin
            mHit   = (off >= 0 && off < 16) && (csr_rd || csr_wr);
            mRdata = csr_rd ? modelRead(off) : 32'd0;
        end
        setv = '0;
        clr  = '0;
        for (int k = 0; k < NT; k++) begin
            if (wr && off == 4 + 2 * k) mCount[k] = csr_wdata;
            else if (mCount[k] == 1) begin setv[k] = 1'b1; mCount[k] = mReload[k]; end
            else if (mCount[k] != 0) mCount[k] = mCount[k] - 1;
            if (wr && off == 5 + 2 * k) mReload[k] = csr_wdata;
        end
        for (int j = 0; j < NE; j++) if (EDGE[j] && mD2[j] && !mD3[j]) setv[NT + j] = 1'b1;
        if (wr && off == 0) clr = csr_wdata;
        if (ackOk) clr[mCause] = 1'b1;
        for (int s = 0; s < NSRC; s++)
            if (isStoredSrc(s)) mStored[s] = setv[s] | (mStored[s] & !clr[s]);
        if (wr && off == 1) mEnable = csr_wdata & SRCM;
        if (wr && off == 3) mVecbase = {csr_wdata[31:3], 3'b000};
        if (eoiOk && lowIns >= 0) mInserv[lowIns] = 1'b0;
        if (ackOk) mInserv[mCause] = 1'b1;
        mReq = reqN;
        if (reqN) begin
            mCause  = 5'(win);
            mVector = oldVec + 32'(8 * win);
        end
        mD3 = mD2; mD2 = mD1; mD1 = ext_irq;
    endtask

    task automatic tick();
        @(posedge clock);
        if (!reset) modelReset();
        else modelStep();
        #1;
        checkOutput("modelReq", 32'(irq_req), 32'(mReq));
        if (mReq) begin
            checkOutput("modelCause", 32'(irq_cause), 32'(mCause));
            checkOutput("modelVector", irq_vector, mVector);
        end
        checkOutput("modelHit", 32'(csr_hit), 32'(mHit));
        checkOutput("modelRdata", csr_rdata, mRdata);
    endtask

    task automatic csrWrite(input int off, input logic [31:0] data);
        csr_wr = 1'b1; csr_addr = 13'(int'(BASE) + off); csr_wdata = data;
        tick();
        csr_wr = 1'b0;
    endtask

    task automatic csrRead(input int off, input logic [31:0] exp, input string name);
        csr_rd = 1'b1; csr_addr = 13'(int'(BASE) + off);
        tick();
        csr_rd = 1'b0;
        checkOutput(name, csr_rdata, exp);
    endtask

    task automatic pulseAck();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    endtask

    task automatic pulseEoi();
        irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    endtask

    task automatic waitReq(input int maxCycles, input string name, output int used);
        used = 0;
        while (!irq_req && used < maxCycles) begin tick(); used++; end
        if (!irq_req) begin
            checks++; failures++;
            $display("[TB] FAIL %s: got no request expected request within %0d cycles", name, maxCycles);
        end
    endtask

    // Randomized inputs for one cycle
    task automatic applyStimulus();
        int offs [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 12, 20, -1};
        int off;
        stall         = ($urandom_range(0, 7) == 0);
        irq_global_en = ($urandom_range(0, 15) != 0);
        irq_ack       = ($urandom_range(0, 2) == 0);
        irq_eoi       = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 3) == 0) ext_irq = NE'($urandom);
        off = offs[$urandom_range(0, 10)];
        csr_addr = 13'(int'(BASE) + off);
        csr_rd   = $urandom_range(0, 1) == 1;
        csr_wr   = ($urandom_range(0, 9) < 3);
        csr_wdata = (off == 4 || off == 6) ? 32'($urandom_range(0, 9)) : $urandom;
        tick();
    endtask

    int used;

    initial begin
        reset = 1'b0; stall = 1'b0; ext_irq = '0; csr_wr = 1'b0; csr_rd = 1'b0;
        csr_addr = '0; csr_wdata = '0; irq_global_en = 1'b0; irq_ack = 1'b0; irq_eoi = 1'b0;
        modelReset();
        tick(); tick(); tick();
        checkOutput("resetReq", 32'(irq_req), 32'd0);
        checkOutput("resetCause", 32'(irq_cause), 32'd0);
        reset = 1'b1;

        // Register map table
        tbl[0]  = '{1'b0, 3,  32'h0,        32'hffff_0008, 1'b1};
        tbl[1]  = '{1'b0, 0,  32'h0,        32'h0,         1'b1};
        tbl[2]  = '{1'b0, 1,  32'h0,        32'h0,         1'b1};
        tbl[3]  = '{1'b0, 2,  32'h0,        32'h0,         1'b1};
        tbl[4]  = '{1'b1, 1,  32'hffff_ffff, 32'h0,        1'b1};
        tbl[5]  = '{1'b0, 1,  32'h0,        32'h0000_03ff, 1'b1};
        tbl[6]  = '{1'b1, 3,  32'h1234_567f, 32'h0,        1'b1};
        tbl[7]  = '{1'b0, 3,  32'h0,        32'h1234_5678, 1'b1};
        tbl[8]  = '{1'b1, 3,  32'hffff_0008, 32'h0,        1'b1};
        tbl[9]  = '{1'b1, 7,  32'h0000_abcd, 32'h0,        1'b1};
        tbl[10] = '{1'b0, 7,  32'h0,        32'h0000_abcd, 1'b1};
        tbl[11] = '{1'b0, 12, 32'h0,        32'h0,         1'b1};
        tbl[12] = '{1'b1, 12, 32'hffff_ffff, 32'h0,        1'b1};
        tbl[13] = '{1'b0, 12, 32'h0,        32'h0,         1'b1};
        tbl[14] = '{1'b0, 20, 32'h0,        32'h0,         1'b0};
        tbl[15] = '{1'b0, -1, 32'h0,        32'h0,         1'b0};
        tbl[16] = '{1'b1, 1,  32'h0,        32'h0,         1'b1};
        tbl[17] = '{1'b0, 1,  32'h0,        32'h0,         1'b1};
        tbl[18] = '{1'b0, 6,  32'h0,        32'h0,         1'b1};
        for (int i = 0; i < 19; i++) begin
            if (tbl[i].isWrite) csrWrite(tbl[i].off, tbl[i].wdata);
            else begin
                csrRead(tbl[i].off, tbl[i].expData, $sformatf("tbl%0d data", i));
            end
            checkOutput($sformatf("tbl%0d hit", i), 32'(csr_hit), 32'(tbl[i].expHit));
        end
        checkOutput("idleReq", 32'(irq_req), 32'd0);

        // Timer 0 periodic interrupt
        irq_global_en = 1'b1;
        csrWrite(5, 32'd3);
        csrWrite(1, 32'd1);
        csrWrite(4, 32'd3);
        waitReq(10, "timerReq", used);
        checkOutput("timerLatency", 32'(used), 32'd4);
        checkOutput("timerCause", 32'(irq_cause), 32'd0);
        checkOutput("timerVector", irq_vector, 32'hffff_0008);
        csrRead(4, 32'd2, "timerReloaded");
        pulseAck();
        checkOutput("timerAckDrop", 32'(irq_req), 32'd0);
        csrWrite(4, 32'd0);
        csrWrite(5, 32'd0);
        csrWrite(0, 32'h3ff);
        pulseEoi();
        csrRead(2, 32'h0, "timerEoi");

        // Edge-triggered external line 2 (source 4)
        csrWrite(1, 32'h10);
        ext_irq = 8'h04; tick(); tick(); ext_irq = '0;
        waitReq(10, "edgeReq", used);
        checkOutput("edgeCause", 32'(irq_cause), 32'd4);
        checkOutput("edgeVector", irq_vector, 32'hffff_0028);
        pulseAck();
        checkOutput("edgeAckDrop", 32'(irq_req), 32'd0);
        csrRead(2, 32'h10, "edgeInserv");
        csrRead(0, 32'h0, "edgeCleared");
        ext_irq = 8'h04; tick(); tick(); ext_irq = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("edgeNoPreempt", 32'(irq_req), 32'd0);
        end
        csrRead(0, 32'h10, "edgeRepend");

        // Nesting: timer 0 preempts source 4
        csrWrite(1, 32'h11);
        csrWrite(4, 32'd2);
        waitReq(10, "nestReq", used);
        checkOutput("nestCause", 32'(irq_cause), 32'd0);
        checkOutput("nestVector", irq_vector, 32'hffff_0008);
        pulseAck();
        csrRead(2, 32'h11, "nestInserv2");
        pulseEoi();
        csrRead(2, 32'h10, "nestInserv1");
        pulseEoi();
        csrRead(2, 32'h00, "nestInserv0");
        csrWrite(0, 32'h3ff);
        csrWrite(1, 32'h0);

        // W1C racing a timer expiry, then a held level line
        irq_global_en = 1'b0;
        csrWrite(4, 32'd3);
        tick(); tick();
        csrWrite(0, 32'h1);
        csrRead(0, 32'h1, "setBeatsW1c");
        csrWrite(0, 32'h1);
        csrRead(0, 32'h0, "w1cClears");
        ext_irq = 8'h20;
        tick(); tick(); tick(); tick();
        csrWrite(0, 32'h80);
        csrRead(0, 32'h80, "levelIgnoresW1c");
        ext_irq = '0;
        tick(); tick(); tick();
        csrRead(0, 32'h0, "levelFollowsLine");

        // Asynchronous reset mid-operation
        irq_global_en = 1'b1;
        csrWrite(1, 32'h80);
        csrWrite(3, 32'h8000_0100);
        csrWrite(5, 32'd50);
        csrWrite(4, 32'd50);
        ext_irq = 8'h20;
        waitReq(10, "levelReq", used);
        checkOutput("levelCause", 32'(irq_cause), 32'd7);
        checkOutput("levelVector", irq_vector, 32'h8000_0138);
        #2 reset = 1'b0;
        #1;
        modelReset();
        checkOutput("asyncResetReq", 32'(irq_req), 32'd0);
        checkOutput("asyncResetVector", irq_vector, 32'hffff_0008);
        tick(); tick();
        ext_irq = '0;
        reset = 1'b1;
        csrRead(4, 32'd0, "resetCount");
        csrRead(3, 32'hffff_0008, "resetVecbase");
        csrRead(1, 32'h0, "resetEnable");

        // Randomized run against the model
        for (int i = 0; i < 800; i++) applyStimulus();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
